// File: rtl/wb_host_initiator.sv
// Wishbone classic single-transfer initiator: turns one command into one bus
// cycle with an ACK timeout, and returns one response under back-pressure.
module wb_host_initiator #(
   parameter int TIMEOUT = 16,
   parameter int ERRW    = 8
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic              cmd_we,
   input  logic [31:0]       cmd_adr,
   input  logic [31:0]       cmd_dat,
   input  logic [3:0]        cmd_sel,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_dat,
   output logic              rsp_err,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   output logic              wbm_we_o,
   output logic [3:0]        wbm_sel_o,
   output logic [31:0]       wbm_adr_o,
   output logic [31:0]       wbm_dat_o,
   input  logic              wbm_ack_i,
   input  logic [31:0]       wbm_dat_i,
   output logic              busy,
   output logic [ERRW-1:0]   err_count
);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t      state, state_next;
   logic [15:0] timer;
   logic        timeout_hit;

   assign timeout_hit = (timer == 16'(TIMEOUT - 1));

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) state <= IDLE;
      else          state <= state_next;
   end

   // Handshake and bus strobes are decoded from state only, so cmd_ready has
   // no combinational path from cmd_valid.
   always_comb begin
      // NOTE: every output of this block gets a default first; a missed
      // branch would otherwise infer a latch.
      state_next = state;
      cmd_ready  = 1'b0;
      rsp_valid  = 1'b0;
      wbm_cyc_o  = 1'b0;
      wbm_stb_o  = 1'b0;
      busy       = 1'b1;
      unique case (state)
         IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) state_next = BUS;
         end
         BUS: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            if (wbm_ack_i || timeout_hit) state_next = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            if (rsp_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         timer     <= '0;
         wbm_we_o  <= 1'b0;
         wbm_sel_o <= '0;
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         rsp_dat   <= '0;
         rsp_err   <= 1'b0;
         err_count <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (cmd_valid) begin
                  wbm_we_o  <= cmd_we;
                  wbm_sel_o <= cmd_sel;
                  wbm_adr_o <= cmd_adr;
                  wbm_dat_o <= cmd_dat;
                  timer     <= '0;
               end
            end
            BUS: begin
               // ACK on the final timer cycle still counts as success.
               if (wbm_ack_i) begin
                  rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
                  rsp_err   <= 1'b0;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= '0;
               end else if (timeout_hit) begin
                  rsp_dat   <= '0;
                  rsp_err   <= 1'b1;
                  wbm_we_o  <= 1'b0;
                  wbm_sel_o <= '0;
                  if (err_count != {ERRW{1'b1}}) err_count <= err_count + 1'b1;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_host_initiator.sv
// Self-checking bench for wb_host_initiator: directed test-plan steps followed
// by randomized transfers, all judged against a transaction-level model.
`timescale 1ns/1ps
module tb_wb_host_initiator;

   localparam int TIMEOUT = 16;
   localparam int ERRW    = 2;
   localparam int ERR_MAX = (1 << ERRW) - 1;

   logic            wb_clk_i, wb_rst_i;
   logic            cmd_valid, cmd_ready, cmd_we;
   logic [31:0]     cmd_adr, cmd_dat;
   logic [3:0]      cmd_sel;
   logic            rsp_valid, rsp_ready, rsp_err;
   logic [31:0]     rsp_dat;
   logic            wbm_cyc_o, wbm_stb_o, wbm_we_o;
   logic [3:0]      wbm_sel_o;
   logic [31:0]     wbm_adr_o, wbm_dat_o;
   logic            wbm_ack_i;
   logic [31:0]     wbm_dat_i;
   logic            busy;
   logic [ERRW-1:0] err_count;

   int errors = 0;
   int checks = 0;
   int err_model = 0;

   wb_host_initiator #(.TIMEOUT(TIMEOUT), .ERRW(ERRW)) dut (
      .wb_clk_i (wb_clk_i),  .wb_rst_i (wb_rst_i),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
      .cmd_adr  (cmd_adr),   .cmd_dat  (cmd_dat),   .cmd_sel(cmd_sel),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat),
      .rsp_err  (rsp_err),
      .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
      .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
      .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
      .busy     (busy),      .err_count(err_count)
   );

   initial wb_clk_i = 1'b0;
   always #5 wb_clk_i = ~wb_clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog: observed=no_finish expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_idle_reset_state();
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_err",   32'(rsp_err),   32'd0);
      check("rst_rsp_dat",   rsp_dat,        32'd0);
      check("rst_cyc_stb",   32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
      check("rst_we_sel",    32'({wbm_we_o, wbm_sel_o}),  32'd0);
      check("rst_adr",       wbm_adr_o,      32'd0);
      check("rst_dat_o",     wbm_dat_o,      32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
   endtask

   // One command/response exchange. Called and returns at a falling edge.
   // ack_at: index of the STB cycle on which the slave ACKs (-1 = never).
   task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int ack_at, input logic [31:0] rdata,
                       input int rsp_wait, input bit pend_next);
      bit          exp_err;
      int          exp_stb;
      logic [31:0] exp_dat;
      int          stb_n;
      exp_err = !(ack_at >= 0 && ack_at < TIMEOUT);
      exp_stb = exp_err ? TIMEOUT : ack_at + 1;
      exp_dat = (we || exp_err) ? 32'd0 : rdata;
      if (exp_err && err_model < ERR_MAX) err_model++;

      check("cmd_ready_before", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
      cmd_adr   = $urandom;
      cmd_dat   = $urandom;

      stb_n = 0;
      while (wbm_stb_o === 1'b1 && stb_n < TIMEOUT + 4) begin
         check("bus_ctl", 32'({wbm_cyc_o, wbm_we_o, wbm_sel_o, cmd_ready}), 32'({1'b1, we, sel, 1'b0}));
         check("bus_adr", wbm_adr_o, adr);
         if (we) check("bus_dat_o", wbm_dat_o, dat);
         wbm_ack_i = (stb_n == ack_at);
         wbm_dat_i = wbm_ack_i ? rdata : $urandom;
         stb_n++;
         @(negedge wb_clk_i);
      end
      wbm_ack_i = 1'b0;
      check("stb_cycles",  32'(stb_n), 32'(exp_stb));
      check("cyc_drop",    32'({wbm_cyc_o, wbm_stb_o}), 32'd0);
      check("rsp_valid",   32'(rsp_valid), 32'd1);
      check("rsp_dat",     rsp_dat, exp_dat);
      check("rsp_err",     32'(rsp_err), 32'(exp_err));
      check("err_count",   32'(err_count), 32'(err_model));
      check("we_sel_clr",  32'({wbm_we_o, wbm_sel_o}), 32'd0);
      check("resp_busy",   32'({busy, cmd_ready}), 32'b10);

      for (int i = 0; i < rsp_wait; i++) begin
         rsp_ready = 1'b0;
         wbm_ack_i = 1'($urandom);
         if (pend_next) cmd_valid = 1'b1;
         @(negedge wb_clk_i);
         check("hold_valid", 32'({rsp_valid, cmd_ready, wbm_cyc_o}), 32'b100);
         check("hold_dat",   rsp_dat, exp_dat);
         check("hold_err",   32'(rsp_err), 32'(exp_err));
      end
      wbm_ack_i = 1'b0;
      rsp_ready = 1'b1;
      @(negedge wb_clk_i);
      rsp_ready = 1'b0;
      check("after_rsp", 32'({rsp_valid, cmd_ready, busy, wbm_cyc_o}), 32'b0100);
   endtask

   int sat_exp [5] = '{1, 2, 3, 3, 3};

   initial begin
      int seen;
      wb_rst_i = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = '0; cmd_dat = '0;
      cmd_sel = '0; rsp_ready = 1'b0; wbm_ack_i = 1'b0; wbm_dat_i = '0;
      repeat (3) @(negedge wb_clk_i);
      check_idle_reset_state();
      wb_rst_i = 1'b0;

      // Write with two wait states, then zero-wait read.
      xfer(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 2, 32'h0, 0, 1'b0);
      xfer(1'b0, 32'h3000_0010, 32'h0, 4'hF, 0, 32'h1234_5678, 0, 1'b0);

      // Timeout, then ACK on the very last allowed STB cycle.
      xfer(1'b0, 32'h3000_0020, 32'h0, 4'h3, -1, 32'hAAAA_5555, 1, 1'b0);
      xfer(1'b0, 32'h3000_0024, 32'h0, 4'hC, TIMEOUT - 1, 32'hCAFE_F00D, 0, 1'b0);

      // Back-pressure with a pending command queued behind the response.
      xfer(1'b0, 32'h3000_0030, 32'h0, 4'hF, 1, 32'h0BAD_F00D, 10, 1'b1);
      xfer(1'b1, 32'h3000_0034, 32'h5A5A_A5A5, 4'h5, 0, 32'h0, 0, 1'b0);

      // Stray ACK while idle.
      wbm_ack_i = 1'b1; wbm_dat_i = 32'hFFFF_FFFF;
      @(negedge wb_clk_i);
      wbm_ack_i = 1'b0;
      check("stray_ack", 32'({rsp_valid, busy, wbm_cyc_o, cmd_ready}), 32'b0001);
      @(negedge wb_clk_i);
      check("stray_ack2", 32'(rsp_valid), 32'd0);

      // Reset while waiting for ACK: transfer abandoned, no response.
      cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
      @(negedge wb_clk_i);
      cmd_valid = 1'b0;
      repeat (3) begin
         check("pre_rst_stb", 32'(wbm_stb_o), 32'd1);
         @(negedge wb_clk_i);
      end
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i  = 1'b0;
      err_model = 0;
      check("mid_rst_bus", 32'({wbm_cyc_o, wbm_stb_o, rsp_valid, busy}), 32'd0);
      check("mid_rst_cnt", 32'({err_count, cmd_ready}), 32'b001);
      seen = 0;
      for (int i = 0; i < TIMEOUT + 4; i++) begin
         wbm_ack_i = 1'($urandom);
         @(negedge wb_clk_i);
         if (rsp_valid !== 1'b0 || wbm_cyc_o !== 1'b0) seen++;
      end
      wbm_ack_i = 1'b0;
      check("no_rsp_after_rst", 32'(seen), 32'd0);

      // Saturating timeout counter.
      for (int i = 0; i < 5; i++) begin
         xfer(1'($urandom), $urandom, $urandom, 4'($urandom), -1, $urandom, 0, 1'b0);
         check("sat_count", 32'(err_count), 32'(sat_exp[i]));
      end

      // Randomized transfers: latency mix, timeouts, back-pressure, queued commands.
      wb_rst_i = 1'b1;
      @(negedge wb_clk_i);
      wb_rst_i  = 1'b0;
      err_model = 0;
      for (int n = 0; n < 40; n++) begin
         int r, ack_at;
         r = $urandom_range(0, 9);
         if (r < 6)      ack_at = $urandom_range(0, 4);
         else if (r < 8) ack_at = $urandom_range(TIMEOUT - 2, TIMEOUT - 1);
         else            ack_at = -1;
         xfer(1'($urandom), $urandom, $urandom, 4'($urandom), ack_at, $urandom,
              $urandom_range(0, 3), 1'($urandom));
         cmd_valid = 1'b0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
